// File: rtl/seven_seg_scan_mux.sv
// Multiplexed seven-segment driver: round-robin digit scan with PWM dimming,
// de-ghost dark sub-slot, leading-zero blanking and frame-synchronous input capture.
module seven_seg_scan_mux #(
  parameter int DIGITS         = 4,
  parameter int DIM_BITS       = 3,
  parameter bit ACTIVE_LOW_AN  = 1'b1,
  parameter bit ACTIVE_LOW_SEG = 1'b1
) (
  input  logic                  base_scan_clock,
  input  logic                  RESETn,
  input  logic                  enable,
  input  logic [4*DIGITS-1:0]   digit_data,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  blank_lz,
  input  logic [DIM_BITS-1:0]   brightness,
  output logic [DIGITS-1:0]     scan_out,
  output logic [6:0]            seg_out,
  output logic                  dp_out,
  output logic                  frame_done
);

  localparam int                  SEL_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [DIM_BITS-1:0] SUB_MAX  = {DIM_BITS{1'b1}};
  localparam logic [SEL_W-1:0]    SEL_LAST = SEL_W'(DIGITS - 1);
  localparam logic [DIGITS-1:0]   AN_INV   = {DIGITS{ACTIVE_LOW_AN}};
  localparam logic [6:0]          SEG_INV  = {7{ACTIVE_LOW_SEG}};

  logic [DIM_BITS-1:0] sub_q, sub_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic [4*DIGITS-1:0] data_sh_q, data_sh_d;
  logic [DIGITS-1:0]   dp_sh_q, dp_sh_d;
  logic                blz_sh_q, blz_sh_d;
  logic [DIM_BITS-1:0] bright_sh_q, bright_sh_d;
  logic                primed_q, primed_d;
  logic [DIGITS-1:0]   scan_q, scan_d;
  logic [6:0]          seg_q, seg_d;
  logic                dp_q, dp_d;
  logic                frame_done_q, frame_done_d;

  logic [3:0] nib;
  logic       dp_sel;
  logic       blank_sel;
  logic       upper_zero;
  logic       wrap;
  logic       on;
  logic [6:0] seg_lit;

  // Pick the selected digit's shadowed nibble/dp and decide whether it is a
  // leading zero: blanked when it and every nibble above it are zero.
  always_comb begin
    nib        = 4'h0;
    dp_sel     = 1'b0;
    blank_sel  = 1'b0;
    upper_zero = 1'b1;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      upper_zero = upper_zero && (data_sh_q[4*k +: 4] == 4'h0);
      if (sel_q == SEL_W'(k)) begin
        nib       = data_sh_q[4*k +: 4];
        dp_sel    = dp_sh_q[k];
        blank_sel = blz_sh_q && (k != 0) && upper_zero;
      end
    end
  end

  always_comb begin
    seg_lit = 7'b0000000;
    case (nib)
      4'h0: seg_lit = 7'b0111111;
      4'h1: seg_lit = 7'b0000110;
      4'h2: seg_lit = 7'b1011011;
      4'h3: seg_lit = 7'b1001111;
      4'h4: seg_lit = 7'b1100110;
      4'h5: seg_lit = 7'b1101101;
      4'h6: seg_lit = 7'b1111101;
      4'h7: seg_lit = 7'b0000111;
      4'h8: seg_lit = 7'b1111111;
      4'h9: seg_lit = 7'b1101111;
      4'hA: seg_lit = 7'b1110111;
      4'hB: seg_lit = 7'b1111100;
      4'hC: seg_lit = 7'b0111001;
      4'hD: seg_lit = 7'b1011110;
      4'hE: seg_lit = 7'b1111001;
      4'hF: seg_lit = 7'b1110001;
      default: seg_lit = 7'b0000000;
    endcase
  end

  always_comb begin
    sub_d        = sub_q;
    sel_d        = sel_q;
    data_sh_d    = data_sh_q;
    dp_sh_d      = dp_sh_q;
    blz_sh_d     = blz_sh_q;
    bright_sh_d  = bright_sh_q;
    primed_d     = primed_q;
    frame_done_d = 1'b0;
    wrap         = (sub_q == SUB_MAX) && (sel_q == SEL_LAST);

    // Sub-slot 0 is always dark so the anode switch never ghosts segments.
    on = enable && (sub_q != '0) && (sub_q <= bright_sh_q) && !blank_sel;

    if (enable) begin
      sub_d = sub_q + DIM_BITS'(1);
      if (sub_q == SUB_MAX) begin
        sel_d = (sel_q == SEL_LAST) ? '0 : sel_q + SEL_W'(1);
      end
      // Shadows change only at frame boundaries (or once at priming) so a
      // frame never mixes old and new input values.
      if (!primed_q || wrap) begin
        data_sh_d   = digit_data;
        dp_sh_d     = dp_in;
        blz_sh_d    = blank_lz;
        bright_sh_d = brightness;
      end
      primed_d     = 1'b1;
      frame_done_d = wrap;
    end

    scan_d = (on ? (DIGITS'(1) << sel_q) : '0) ^ AN_INV;
    seg_d  = (on ? seg_lit : 7'b0000000) ^ SEG_INV;
    dp_d   = (on && dp_sel) ^ ACTIVE_LOW_SEG;
  end

  always_ff @(posedge base_scan_clock or posedge RESETn) begin
    if (RESETn) begin
      sub_q        <= '0;
      sel_q        <= '0;
      data_sh_q    <= '0;
      dp_sh_q      <= '0;
      blz_sh_q     <= 1'b0;
      bright_sh_q  <= '0;
      primed_q     <= 1'b0;
      scan_q       <= AN_INV;
      seg_q        <= SEG_INV;
      dp_q         <= ACTIVE_LOW_SEG;
      frame_done_q <= 1'b0;
    end else begin
      sub_q        <= sub_d;
      sel_q        <= sel_d;
      data_sh_q    <= data_sh_d;
      dp_sh_q      <= dp_sh_d;
      blz_sh_q     <= blz_sh_d;
      bright_sh_q  <= bright_sh_d;
      primed_q     <= primed_d;
      scan_q       <= scan_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign scan_out   = scan_q;
  assign seg_out    = seg_q;
  assign dp_out     = dp_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seven_seg_scan_mux.sv
// Bench for seven_seg_scan_mux (default parameters): directed phases plus a
// randomized tail, checked against a frame-position reference model.
module tb_seven_seg_scan_mux;

  logic        clk;
  logic        rst;
  logic        en;
  logic [15:0] data;
  logic [3:0]  dp;
  logic        blz;
  logic [2:0]  bright;
  logic [3:0]  scan_out;
  logic [6:0]  seg_out;
  logic        dp_out;
  logic        frame_done;

  int checks = 0;
  int errors = 0;

  // Active-high gfedcba patterns for 0..F.
  localparam logic [6:0] SEG_TAB [16] = '{
    7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
    7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
    7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
    7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001};

  // Reference state: count of enabled edges since reset plus captured inputs.
  int          n;
  bit          primed;
  logic [15:0] m_data;
  logic [3:0]  m_dp;
  logic        m_blz;
  logic [2:0]  m_bright;
  logic [12:0] exp_q[$];

  seven_seg_scan_mux dut (
    .base_scan_clock (clk),
    .RESETn          (rst),
    .enable          (en),
    .digit_data      (data),
    .dp_in           (dp),
    .blank_lz        (blz),
    .brightness      (bright),
    .scan_out        (scan_out),
    .seg_out         (seg_out),
    .dp_out          (dp_out),
    .frame_done      (frame_done)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    n        = 0;
    primed   = 1'b0;
    m_data   = '0;
    m_dp     = '0;
    m_blz    = 1'b0;
    m_bright = '0;
    exp_q.delete();
  endtask

  // Called #1 after an edge: pulse reset, check the asynchronous response.
  task automatic do_reset();
    rst = 1'b1;
    #2;
    check("rst_scan", 16'(scan_out), 16'hF);
    check("rst_seg", 16'(seg_out), 16'h7F);
    check("rst_dp", 16'(dp_out), 16'h1);
    check("rst_fd", 16'(frame_done), 16'h0);
    @(posedge clk);
    #1;
    check("rst_hold_scan", 16'(scan_out), 16'hF);
    rst = 1'b0;
    model_reset();
  endtask

  // One clock: predict from the current position/shadows, advance the model,
  // then compare the registered outputs after the edge.
  task automatic step();
    int          sub;
    int          dig;
    bit          blank;
    bit          on;
    logic [15:0] tmp;
    logic [3:0]  nib;
    logic [3:0]  e_scan;
    logic [6:0]  e_seg;
    logic        e_dp;
    logic        e_fd;
    logic [12:0] e;
    sub   = n % 8;
    dig   = (n / 8) % 4;
    tmp   = m_data >> (4 * dig);
    nib   = tmp[3:0];
    blank = m_blz && (dig != 0) && (tmp == 16'h0);
    on    = en && (sub >= 1) && (sub <= int'(m_bright)) && !blank;
    e_scan = on ? ~(4'b0001 << dig) : 4'hF;
    e_seg  = on ? ~SEG_TAB[nib] : 7'h7F;
    e_dp   = ~(on && m_dp[dig]);
    e_fd   = en && (n % 32 == 31);
    exp_q.push_back({e_fd, e_dp, e_seg, e_scan});
    if (en) begin
      if (!primed || (n % 32 == 31)) begin
        m_data   = data;
        m_dp     = dp;
        m_blz    = blz;
        m_bright = bright;
      end
      primed = 1'b1;
      n++;
    end
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check("scan", 16'(scan_out), 16'(e[3:0]));
    check("seg", 16'(seg_out), 16'(e[10:4]));
    check("dp", 16'(dp_out), 16'(e[11]));
    check("frame_done", 16'(frame_done), 16'(e[12]));
  endtask

  task automatic run(input int cycles);
    for (int i = 0; i < cycles; i++) step();
  endtask

  initial begin
    rst    = 1'b0;
    en     = 1'b0;
    data   = 16'h1234;
    dp     = 4'h0;
    blz    = 1'b0;
    bright = 3'd7;
    #1;
    do_reset();

    // Scan order, full brightness
    en = 1'b1;
    run(2);
    check("digit0_anode", 16'(scan_out), 16'hE);
    check("digit0_seg4", 16'(seg_out), 16'(7'b0011001));
    run(70);

    // Brightness extremes
    bright = 3'd0;
    run(40);
    bright = 3'd2;
    run(40);

    // Leading-zero suppression
    bright = 3'd7;
    blz    = 1'b1;
    data   = 16'h0050;
    run(40);
    data = 16'h0000;
    run(40);
    blz = 1'b0;
    run(40);

    // Mid-frame changes must wait for the frame boundary
    run(10);
    data = 16'hABCD;
    dp   = 4'b0100;
    run(50);

    // Enable pause mid-slot, then resume
    run(3);
    en = 1'b0;
    run(5);
    en = 1'b1;
    run(20);

    // Reset mid-frame
    run(13);
    do_reset();
    run(40);

    // Randomized tail
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 4) == 0) data = 16'($urandom());
      if ($urandom_range(0, 4) == 0) data = 16'($urandom_range(0, 255));
      if ($urandom_range(0, 6) == 0) dp = 4'($urandom());
      if ($urandom_range(0, 9) == 0) blz = 1'($urandom());
      if ($urandom_range(0, 9) == 0) bright = 3'($urandom());
      en = ($urandom_range(0, 9) != 0);
      step();
      if (i == 400) do_reset();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seven_seg_scan_mux.md
# seven_seg_scan_mux

Parametrised multiplexed seven-segment display driver for DIGITS common-anode or common-cathode digits. It scans digits round-robin from base_scan_clock and decodes each digit's hex nibble to segments. It also provides PWM brightness, a de-ghosting dark sub-slot, per-digit decimal points, leading-zero suppression and tear-free frame-synchronous input capture. It sits between the clock divider's scan tap and the board's anode/segment pins, replacing the fixed 4-digit anode sequencer.

## Interface
Parameters:
- DIGITS, 4: number of digits, legal 1..8.
- DIM_BITS, 3: sub-slot counter width; each digit slot is 2^DIM_BITS clocks; legal 1..6.
- ACTIVE_LOW_AN, 1: 1 = anode outputs active-low.
- ACTIVE_LOW_SEG, 1: 1 = segment and dp outputs active-low.

Ports:
- base_scan_clock, in, 1: scan clock; all state on rising edge.
- RESETn, in, 1: reset, asynchronous, active-high (despite name).
- enable, in, 1: 1 = scan runs; 0 = freeze counters, display dark.
- digit_data, in, 4*DIGITS: nibble k = digit_data[4k+3:4k] drives digit k; digit 0 least significant.
- dp_in, in, DIGITS: bit k lights decimal point of digit k.
- blank_lz, in, 1: 1 = leading-zero suppression on.
- brightness, in, DIM_BITS: on-time in sub-slots per digit slot.
- scan_out, out, DIGITS: anode enables; bit k = digit k.
- seg_out, out, 7: segments {g,f,e,d,c,b,a}.
- dp_out, out, 1: decimal point segment.
- frame_done, out, 1: one-cycle pulse per completed frame.

## Operation
- State: sub_cnt (DIM_BITS), sel (max(1,clog2(DIGITS)) bits), shadow copies of digit_data, dp_in, blank_lz and brightness, plus a primed flag.
- Enabled edge: sub_cnt increments and wraps at 2^DIM_BITS-1.
- sel increments when sub_cnt == 2^DIM_BITS-1; sel wraps from DIGITS-1 to 0.
- Frame wrap edge: the enabled edge with sel == DIGITS-1 and sub_cnt == max.
- Shadow load: shadows load from inputs on the first enabled edge after reset (primed set) and on every frame wrap edge. They never load at any other time.
- Lit condition for the current (sel, sub_cnt):
  - on = enable && sub_cnt >= 1 && sub_cnt <= bright_sh && !blank(sel).
  - sub_cnt == 0 is always dark (de-ghost guard).
  - brightness 0 = display off.
  - Maximum duty is (2^DIM_BITS-1)/2^DIM_BITS.
- blank(k) is 1 when all of the following hold, and 0 otherwise:
  - blank_lz_sh = 1,
  - k != 0,
  - nibble k == 0,
  - every nibble above k == 0.
  - Digit 0 is never blanked.
- Decode: standard hex 0-F, active-high gfedcba.
  - 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111,
  - 8=1111111, 9=1101111, A=1110111, b=1111100, C=0111001, d=1011110, E=1111001, F=1110001.
- Output registers, loaded every edge, then polarity-inverted per parameter:
  - scan_out = one-hot(sel) if on, else 0.
  - seg_out = decode(nibble sel of shadow) if on, else 0.
  - dp_out = dp_sh[sel] && on.
- enable = 0:
  - sub_cnt, sel and shadows hold.
  - Outputs go inactive on the next edge.
  - Re-enable resumes from the held position.

## Timing
- Reset (asynchronous, immediate):
  - scan_out all inactive (all 1s when ACTIVE_LOW_AN=1).
  - seg_out and dp_out inactive (7'h7F and 1 when ACTIVE_LOW_SEG=1).
  - frame_done = 0.
  - sub_cnt, sel, shadows and primed = 0.
- Reset asserted mid-frame aborts the frame; the scan restarts at digit 0, sub 0.
- Latency: outputs reflect the (sel, sub_cnt) present before the edge, one cycle later. Outputs computed on a frame wrap edge use the pre-load shadow.
- Frame length is DIGITS*2^DIM_BITS enabled clocks (default 32).
- frame_done is high for exactly one cycle after each frame wrap edge. It does not fire on the priming load.
- Input changes mid-frame are invisible until the cycle after the next frame_done.
- DIGITS=1: sel is constant 0; a frame is one slot.

## Test plan
1. Reset: RESETn=1 -> scan_out=4'b1111, seg_out=7'h7F, dp_out=1, frame_done=0, regardless of the clock.
2. Scan order, defaults, brightness=7, digit_data=16'h1234, enable=1:
   - Anodes cycle 1110, 1101, 1011, 0111.
   - Each is active 7 of 8 clocks; the first clock of each slot is 1111.
   - Digit 0 shows seg_out=7'b0011001 ('4').
   - frame_done pulses every 32 clocks.
3. Brightness: brightness=0 -> scan_out stays 1111; brightness=2 -> each anode active on exactly sub_cnt 1..2.
4. Leading zeros, blank_lz=1:
   - 16'h0050 -> digits 3,2 dark; digit 1 = 7'b0010010 ('5'); digit 0 = 7'b1000000 ('0').
   - 16'h0000 -> only digit 0 lights.
   - blank_lz=0 -> all four digits light.
5. Tear-free capture: change digit_data and dp_in mid-frame -> outputs unchanged until the cycle after frame_done; dp_in[2]=1 -> dp_out=0 only while digit 2 is lit.
6. Enable and reset mid-slot:
   - enable=0 mid-slot -> outputs inactive next cycle, counters frozen; re-enable continues from the same sel and sub_cnt.
   - RESETn pulse mid-frame -> outputs inactive at once; scan restarts at digit 0.
